// File: rtl/discard_half_pkg.sv
// Shared constants and helpers for the overlap-save output chain.
package discard_half_pkg;

    localparam int DEF_W       = 16;
    localparam int DEF_NFFT    = 32;
    localparam int DEF_DISCARD = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/discard_half.sv
// Overlap-save trimmer: drops the leading DISCARD samples of each NFFT block and
// forwards the rest combinationally, tagged with first/last/index qualifiers.
module discard_half
    import discard_half_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int NFFT    = DEF_NFFT,
    parameter int DISCARD = DEF_DISCARD
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic signed [W-1:0]    i_y_re,
    input  logic signed [W-1:0]    i_y_im,
    input  logic                   i_last,
    output logic                   o_valid,
    output logic signed [W-1:0]    o_y_re,
    output logic signed [W-1:0]    o_y_im,
    output logic                   o_first,
    output logic                   o_last,
    output logic [clog2(NFFT)-1:0] o_idx
);

    localparam int CW = clog2(NFFT);
    localparam logic [CW-1:0] DISC_C = CW'(DISCARD);
    localparam logic [CW-1:0] LAST_C = CW'(NFFT - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    if (DISCARD <= 0 || DISCARD >= NFFT) begin : g_bad_discard
        $error("discard_half: DISCARD must satisfy 0 < DISCARD < NFFT");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blk_end;
    logic          good;

    assign blk_end = i_last || (cnt_q == LAST_C);

    // Early i_last resynchronises the block just like the natural wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (i_valid) begin
            cnt_d = blk_end ? '0 : cnt_q + ONE_C;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reset gating keeps outputs quiet even while inputs toggle during reset.
    assign good    = i_rst && i_valid && (cnt_q >= DISC_C);
    assign o_valid = good;
    assign o_y_re  = good ? i_y_re : '0;
    assign o_y_im  = good ? i_y_im : '0;
    assign o_idx   = good ? (cnt_q - DISC_C) : '0;
    assign o_first = good && (cnt_q == DISC_C);
    assign o_last  = good && blk_end;

endmodule

// File: tb/tb_discard_half.sv
// Directed bench for discard_half with a reference model feeding a scoreboard queue.
module tb_discard_half;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               in_last;
    logic               out_valid;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               out_first;
    logic               out_last;
    logic [4:0]         out_idx;

    discard_half #(.W(16), .NFFT(32), .DISCARD(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_valid (in_valid),
        .i_y_re  (in_re),
        .i_y_im  (in_im),
        .i_last  (in_last),
        .o_valid (out_valid),
        .o_y_re  (out_re),
        .o_y_im  (out_im),
        .o_first (out_first),
        .o_last  (out_last),
        .o_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               v;
        logic               f;
        logic               l;
        logic [4:0]         idx;
        logic signed [15:0] re;
        logic signed [15:0] im;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m      = 0;   // model position within block

    function automatic int data_re(input int k, input int n);
        return (n < 16) ? (100 * k + n) : (1000 + 100 * k + (n - 16));
    endfunction

    // One cycle: drive inputs after the edge, predict, compare mid-cycle.
    task automatic send(input logic rst, input logic v, input int k, input int n,
                        input logic last, input string tag);
        exp_t e;
        exp_t o;
        int   r;
        logic good;
        @(posedge clk);
        #1;
        r        = v ? data_re(k, n) : 12345;
        rst_n    = rst;
        in_valid = v;
        in_re    = 16'(r);
        in_im    = 16'(-r);
        in_last  = last;
        good     = rst && v && (m >= 16);
        e.v      = good;
        e.f      = good && (m == 16);
        e.l      = good && (last || m == 31);
        e.idx    = good ? 5'(m - 16) : 5'd0;
        e.re     = good ? 16'(1000 + 100 * k + (m - 16)) : 16'sd0;
        e.im     = good ? 16'(-(1000 + 100 * k + (m - 16))) : 16'sd0;
        sbq.push_back(e);
        if (!rst) m = 0;
        else if (v) m = (last || m == 31) ? 0 : m + 1;
        @(negedge clk);
        o = {out_valid, out_first, out_last, out_idx, out_re, out_im};
        e = sbq.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s k=%0d n=%0d obs v=%b f=%b l=%b idx=%0d re=%0d im=%0d exp v=%b f=%b l=%b idx=%0d re=%0d im=%0d",
                   tag, k, n, o.v, o.f, o.l, o.idx, o.re, o.im, e.v, e.f, e.l, e.idx, e.re, e.im);
        end
    endtask

    task automatic gap(input int len, input string tag);
        for (int g = 0; g < len; g++) send(1'b1, 1'b0, 0, 0, 1'b0, tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        in_last  = 1'b0;

        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 0, 20, 1'b0, "reset");

        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 32; n++) send(1'b1, 1'b1, k, n, n == 31, "block");
            gap(7, "gap7");
        end

        for (int n = 0; n < 32; n++) begin
            if (n == 5 || n == 20) gap(3, "midgap");
            send(1'b1, 1'b1, 5, n, n == 31, "gapblk");
        end

        for (int n = 0; n <= 20; n++) send(1'b1, 1'b1, 6, n, n == 20, "early");
        for (int n = 0; n < 32; n++) send(1'b1, 1'b1, 7, n, n == 31, "after_early");

        for (int n = 0; n < 24; n++) send(1'b1, 1'b1, 8, n, 1'b0, "pre_rst");
        send(1'b0, 1'b1, 8, 24, 1'b0, "mid_rst");
        send(1'b0, 1'b1, 8, 25, 1'b0, "mid_rst");
        for (int n = 0; n < 32; n++) send(1'b1, 1'b1, 9, n, n == 31, "post_rst");

        for (int n = 0; n < 64; n++) send(1'b1, 1'b1, 10 + n / 32, n % 32, 1'b0, "nolast");
        gap(2, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
